branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequencing controller for the EX-stage branch comparator in the RISC-V pipeline. It accepts a branch or jump from EX and drives the comparator's unsigned-select. It samples the equal/less-than results one cycle later, decides taken/not-taken and redirects the PC. It also stalls the front end while resolving, flushes IF/ID for a fixed squash window, and keeps saturating branch statistics.

## Interface
Parameters:
- XLEN, 32, address width of PC target
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high per taken redirect (legal range 1..7)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  branch/jump instruction present in EX
- is_jal  in  1  instruction is JAL (qualifies br_valid)
- is_jalr  in  1  instruction is JALR (qualifies br_valid)
- br_funct3  in  3  funct3 of conditional branch
- opnd_ready  in  1  forwarding resolved; comparator operands valid
- target  in  XLEN  computed branch/jump target
- br_eq  in  1  comparator equal result
- br_lt  in  1  comparator less-than result
- br_un  out  1  comparator unsigned select
- stall  out  1  hold PC, IF/ID and ID/EX
- pc_sel  out  1  select pc_target as next PC
- pc_target  out  XLEN  latched redirect target
- flush_if  out  1  squash IF/ID register
- flush_id  out  1  squash ID/EX register
- illegal  out  1  one-cycle pulse for funct3 010/011
- branch_cnt  out  CNT_W  resolved branch/jump count
- taken_cnt  out  CNT_W  taken count

## Operation
- States: IDLE, WAIT_OPND, EVAL, FLUSH. Reset state is IDLE.
- IDLE:
  - br_valid & opnd_ready: latch funct3, is_jal, is_jalr and target, then go to EVAL.
  - br_valid & !opnd_ready: go to WAIT_OPND.
- WAIT_OPND:
  - opnd_ready & br_valid: latch the same fields, then go to EVAL.
  - !br_valid: the instruction was killed; return to IDLE with no count update.
- EVAL:
  - br_un = latched funct3[1] for conditional branches, 0 for jumps. br_un is 0 in all other states.
  - taken:
    - funct3 000: br_eq
    - funct3 001: !br_eq
    - funct3 100 and 110: br_lt
    - funct3 101 and 111: !br_lt
    - jal/jalr: 1, and comparator outputs are ignored
    - funct3 010/011: 0, and illegal pulses.
  - branch_cnt increments.
  - If taken:
    - pc_sel = 1 and taken_cnt increments.
    - flush_if and flush_id are asserted.
    - If FLUSH_CYCLES > 1, go to FLUSH with the down-counter set to FLUSH_CYCLES-1; otherwise go to IDLE.
  - Not taken: go to IDLE.
- FLUSH:
  - flush_if and flush_id are high.
  - The counter decrements each cycle; go to IDLE on the cycle it reads 1.
  - br_valid is ignored, because EX holds a squashed bubble.
- stall = (IDLE & br_valid) | WAIT_OPND. Stall is low in EVAL and FLUSH.
- pc_target is valid whenever pc_sel is high. It holds its last latched value otherwise.
- Counters saturate at 2^CNT_W-1; they never wrap.
- is_jal and is_jalr both high: treat as a jump (taken).

## Timing
- Accept at cycle N (stall high). EVAL at N+1: br_un, decision, pc_sel, first flush cycle. FLUSH covers N+2 .. N+FLUSH_CYCLES. Earliest next accept is N+FLUSH_CYCLES+1 if taken, N+2 if not taken.
- Back-to-back: a br_valid in the cycle after a not-taken EVAL is accepted normally.
- Comparator operands are held stable into EVAL because stall was high in the accept cycle.
- Reset values: br_un, stall, pc_sel, flush_if, flush_id, illegal = 0; pc_target, branch_cnt, taken_cnt = 0.
- rst in any state (including mid-FLUSH or EVAL) returns to IDLE on the next edge. No pc_sel or flush in the following cycle, and counters are cleared.

## Test plan
- BEQ, funct3=000, br_eq=1 at EVAL, FLUSH_CYCLES=2, target=0x0000_0100:
  - pc_sel=1 and pc_target=0x100 at N+1.
  - flush high at N+1 and N+2; IDLE at N+3.
  - branch_cnt=1, taken_cnt=1.
- BLTU, funct3=110, br_lt=0: br_un=1 at N+1, pc_sel=0, no flush, taken_cnt unchanged.
- BGE, funct3=101, with opnd_ready low for 3 cycles:
  - stall high for 4 cycles (IDLE accept attempt plus WAIT_OPND); EVAL follows the first opnd_ready cycle.
  - br_un=0 in EVAL; br_lt=0 gives taken.
- funct3=010: illegal pulses exactly 1 cycle in EVAL, pc_sel=0, branch_cnt increments.
- JALR with br_eq=0, br_lt=1: taken regardless of comparator. Then assert rst in the first FLUSH cycle: the next cycle is IDLE with all outputs 0 and counters 0.
- CNT_W=4, 20 taken JALs: branch_cnt and taken_cnt stop at 15.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Signal bundle between the EX stage and the branch sequencing controller.
// The EX side is the master and drives the branch request and comparator results.
// The controller is the slave and drives the PC redirect, the stall/flush controls and the statistics.
interface branch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic             is_jal;
  logic             is_jalr;
  logic [2:0]       br_funct3;
  logic             opnd_ready;
  logic [XLEN-1:0]  target;
  logic             br_eq;
  logic             br_lt;
  logic             br_un;
  logic             stall;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             flush_if;
  logic             flush_id;
  logic             illegal;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, is_jal, is_jalr, br_funct3, opnd_ready, target, br_eq, br_lt,
    input  br_un, stall, pc_sel, pc_target, flush_if, flush_id, illegal,
           branch_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, is_jal, is_jalr, br_funct3, opnd_ready, target, br_eq, br_lt,
    output br_un, stall, pc_sel, pc_target, flush_if, flush_id, illegal,
           branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// EX-stage branch sequencer: accepts a branch or jump, evaluates the comparator,
// redirects the PC, squashes IF/ID for a fixed window and keeps saturating statistics.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  branch_ctrl_if.slave bus,
  output logic [1:0]  dbg_state
);
  // Handshake: br_valid is the request and opnd_ready works as its ready/qualifier.
  // The branch is accepted on the first edge where both are high in IDLE or WAIT_OPND.
  // stall holds the request stable until that edge, and dropping br_valid before it kills the request.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    EVAL      = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       f3_q;
  logic             jal_q, jalr_q;
  logic [XLEN-1:0]  tgt_q;
  logic [2:0]       fcnt_q;
  logic [CNT_W-1:0] branch_q, taken_q;

  logic latch, taken, jump;
  logic br_un, pc_sel, flush, illegal;

  assign jump = jal_q | jalr_q;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    taken   = 1'b0;
    br_un   = 1'b0;
    pc_sel  = 1'b0;
    flush   = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          if (bus.opnd_ready) begin
            latch   = 1'b1;
            state_d = EVAL;
          end else begin
            state_d = WAIT_OPND;
          end
        end
      end
      WAIT_OPND: begin
        if (!bus.br_valid) begin
          state_d = IDLE;
        end else if (bus.opnd_ready) begin
          latch   = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (jump) begin
          taken = 1'b1;
        end else begin
          br_un = f3_q[1];
          case (f3_q)
            3'b000:          taken = bus.br_eq;
            3'b001:          taken = !bus.br_eq;
            3'b100, 3'b110:  taken = bus.br_lt;
            3'b101, 3'b111:  taken = !bus.br_lt;
            default: begin
              taken   = 1'b0;
              illegal = 1'b1;
            end
          endcase
        end
        if (taken) begin
          pc_sel  = 1'b1;
          flush   = 1'b1;
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
      tgt_q    <= '0;
      fcnt_q   <= '0;
      branch_q <= '0;
      taken_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        f3_q   <= bus.br_funct3;
        jal_q  <= bus.is_jal;
        jalr_q <= bus.is_jalr;
        tgt_q  <= bus.target;
      end
      if (state_q == EVAL) begin
        if (branch_q != '1) branch_q <= branch_q + 1'b1;
        if (taken && taken_q != '1) taken_q <= taken_q + 1'b1;
        if (taken) fcnt_q <= FLUSH_INIT;
      end else if (state_q == FLUSH) begin
        fcnt_q <= fcnt_q - 3'd1;
      end
    end
  end

  assign bus.br_un      = br_un;
  assign bus.pc_sel     = pc_sel;
  assign bus.pc_target  = tgt_q;
  assign bus.flush_if   = flush;
  assign bus.flush_id   = flush;
  assign bus.illegal    = illegal;
  assign bus.stall      = ((state_q == IDLE) && bus.br_valid) || (state_q == WAIT_OPND);
  assign bus.branch_cnt = branch_q;
  assign bus.taken_cnt  = taken_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: one task per scenario, hand-computed expectations.
module tb_branch_ctrl;
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;
  int total;
  int bad;
  int exp_branch;
  int exp_taken;

  branch_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_ctrl_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );
  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg_state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.br_valid = 0; bus.is_jal = 0; bus.is_jalr = 0; bus.br_funct3 = 0;
    bus.opnd_ready = 0; bus.target = 0; bus.br_eq = 0; bus.br_lt = 0;
    bus4.br_valid = 0; bus4.is_jal = 0; bus4.is_jalr = 0; bus4.br_funct3 = 0;
    bus4.opnd_ready = 0; bus4.target = 0; bus4.br_eq = 0; bus4.br_lt = 0;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic rdy, input logic [31:0] tgt);
    bus.br_valid = 1; bus.br_funct3 = f3; bus.opnd_ready = rdy; bus.target = tgt;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if ({bus.br_un, bus.stall, bus.pc_sel, bus.flush_if, bus.flush_id, bus.illegal} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.br_un, bus.stall, bus.pc_sel, bus.flush_if, bus.flush_id, bus.illegal}); end
    total++; if (bus.pc_target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", bus.pc_target); end
    total++; if (bus.branch_cnt !== 16'd0 || bus.taken_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.branch_cnt, bus.taken_cnt); end
    exp_branch = 0; exp_taken = 0;
  endtask

  task automatic test_beq_taken();
    @(negedge clk); drive_branch(3'b000, 1, 32'h0000_0100); #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL beq_accept_stall got=%b exp=1", bus.stall); end
    @(negedge clk); idle_inputs(); bus.br_eq = 1; #1;
    exp_branch++; exp_taken++;
    total++; if (bus.pc_sel !== 1'b1) begin bad++; $display("FAIL beq_pc_sel got=%b exp=1", bus.pc_sel); end
    total++; if (bus.pc_target !== 32'h100) begin bad++; $display("FAIL beq_target got=%h exp=100", bus.pc_target); end
    total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b1) begin bad++; $display("FAIL beq_flush1 got=%b%b exp=11", bus.flush_if, bus.flush_id); end
    total++; if (bus.br_un !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL beq_eval_un_stall got=%b%b exp=00", bus.br_un, bus.stall); end
    @(negedge clk); bus.br_eq = 0; #1;
    total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b1 || bus.pc_sel !== 1'b0) begin
      bad++; $display("FAIL beq_flush2 got=%b%b%b exp=110", bus.flush_if, bus.flush_id, bus.pc_sel); end
    total++; if (dbg_state !== 2'd3) begin bad++; $display("FAIL beq_flush_state got=%0d exp=3", dbg_state); end
    @(negedge clk); #1;
    total++; if (dbg_state !== 2'd0 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL beq_idle got=%0d/%b exp=0/0", dbg_state, bus.flush_if); end
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL beq_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_bltu_not_taken();
    @(negedge clk); drive_branch(3'b110, 1, 32'h0000_0200); #1;
    @(negedge clk); idle_inputs(); bus.br_lt = 0; bus.br_eq = 0; #1;
    exp_branch++;
    total++; if (bus.br_un !== 1'b1) begin bad++; $display("FAIL bltu_un got=%b exp=1", bus.br_un); end
    total++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin
      bad++; $display("FAIL bltu_no_redirect got=%b%b%b exp=000", bus.pc_sel, bus.flush_if, bus.flush_id); end
    @(negedge clk); #1;
    total++; if (dbg_state !== 2'd0 || bus.br_un !== 1'b0) begin bad++; $display("FAIL bltu_idle got=%0d/%b exp=0/0", dbg_state, bus.br_un); end
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL bltu_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_bge_wait();
    int stall_n;
    stall_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_branch(3'b101, (i == 3), 32'h0000_0ABC); #1;
      if (bus.stall === 1'b1) stall_n++;
    end
    total++; if (stall_n != 4) begin bad++; $display("FAIL bge_stall_cycles got=%0d exp=4", stall_n); end
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL bge_wait_state got=%0d exp=1", dbg_state); end
    @(negedge clk); idle_inputs(); bus.br_lt = 0; #1;
    exp_branch++; exp_taken++;
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL bge_eval_state got=%0d exp=2", dbg_state); end
    total++; if (bus.br_un !== 1'b0 || bus.pc_sel !== 1'b1 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL bge_eval got=%b%b%b exp=010", bus.br_un, bus.pc_sel, bus.stall); end
    total++; if (bus.pc_target !== 32'hABC) begin bad++; $display("FAIL bge_target got=%h exp=abc", bus.pc_target); end
    repeat (2) @(negedge clk); #1;
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL bge_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_kill();
    @(negedge clk); drive_branch(3'b000, 0, 32'h0000_0444); #1;
    @(negedge clk); idle_inputs(); #1;
    total++; if (dbg_state !== 2'd1 || bus.stall !== 1'b1) begin bad++; $display("FAIL kill_wait got=%0d/%b exp=1/1", dbg_state, bus.stall); end
    @(negedge clk); #1;
    total++; if (dbg_state !== 2'd0 || bus.stall !== 1'b0) begin bad++; $display("FAIL kill_idle got=%0d/%b exp=0/0", dbg_state, bus.stall); end
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL kill_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_illegal();
    @(negedge clk); drive_branch(3'b010, 1, 32'h0000_0555); #1;
    @(negedge clk); idle_inputs(); bus.br_eq = 1; bus.br_lt = 1; #1;
    exp_branch++;
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%b exp=1", bus.illegal); end
    total++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL illegal_redirect got=%b%b exp=00", bus.pc_sel, bus.flush_if); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (bus.illegal !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL illegal_end got=%b/%0d exp=0/0", bus.illegal, dbg_state); end
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL illegal_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_branch(3'b001, 1, 32'h0000_0300); #1;
    @(negedge clk); idle_inputs(); bus.br_eq = 1; #1;
    exp_branch++;
    total++; if (bus.pc_sel !== 1'b0) begin bad++; $display("FAIL b2b_bne_pc_sel got=%b exp=0", bus.pc_sel); end
    @(negedge clk); idle_inputs(); drive_branch(3'b000, 1, 32'h0000_0400); #1;
    total++; if (dbg_state !== 2'd0 || bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0d/%b exp=0/1", dbg_state, bus.stall); end
    @(negedge clk); idle_inputs(); bus.br_eq = 1; #1;
    exp_branch++; exp_taken++;
    total++; if (dbg_state !== 2'd2 || bus.pc_sel !== 1'b1) begin bad++; $display("FAIL b2b_eval got=%0d/%b exp=2/1", dbg_state, bus.pc_sel); end
    total++; if (bus.pc_target !== 32'h400) begin bad++; $display("FAIL b2b_target got=%h exp=400", bus.pc_target); end
    @(negedge clk); idle_inputs(); #1;
    @(negedge clk); #1;
    total++; if (bus.branch_cnt !== 16'(exp_branch) || bus.taken_cnt !== 16'(exp_taken)) begin
      bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d", bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken); end
  endtask

  task automatic test_jalr_reset();
    @(negedge clk); drive_branch(3'b000, 1, 32'h0000_0800); bus.is_jalr = 1; #1;
    @(negedge clk); idle_inputs(); bus.br_eq = 0; bus.br_lt = 1; #1;
    total++; if (bus.pc_sel !== 1'b1 || bus.br_un !== 1'b0) begin bad++; $display("FAIL jalr_eval got=%b%b exp=10", bus.pc_sel, bus.br_un); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (dbg_state !== 2'd3 || bus.flush_if !== 1'b1) begin bad++; $display("FAIL jalr_flush got=%0d/%b exp=3/1", dbg_state, bus.flush_if); end
    rst = 1;
    @(negedge clk); rst = 0; #1;
    exp_branch = 0; exp_taken = 0;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    total++; if ({bus.br_un, bus.stall, bus.pc_sel, bus.flush_if, bus.flush_id, bus.illegal} !== 6'b0) begin
      bad++; $display("FAIL rst_ctrl got=%b exp=000000", {bus.br_un, bus.stall, bus.pc_sel, bus.flush_if, bus.flush_id, bus.illegal}); end
    total++; if (bus.branch_cnt !== 16'd0 || bus.taken_cnt !== 16'd0 || bus.pc_target !== 32'h0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d/%h exp=0/0/0", bus.branch_cnt, bus.taken_cnt, bus.pc_target); end
    @(negedge clk); #1;
    total++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL rst_after got=%b%b exp=00", bus.pc_sel, bus.flush_if); end
  endtask

  task automatic test_saturation();
    int miss;
    miss = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus4.br_valid = 1; bus4.opnd_ready = 1; bus4.is_jal = 1; bus4.is_jalr = (i == 0);
      bus4.br_funct3 = (i == 1) ? 3'b010 : 3'b000; bus4.target = 32'h1000 + 32'(i);
      @(negedge clk);
      bus4.br_valid = 0; bus4.is_jal = 0; bus4.is_jalr = 0; bus4.br_eq = 0; #1;
      if (bus4.pc_sel !== 1'b1 || bus4.illegal !== 1'b0 || bus4.pc_target !== 32'h1000 + 32'(i)) miss++;
      @(negedge clk); #1;
      if (i == 14) begin
        total++; if (bus4.branch_cnt !== 4'd15 || bus4.taken_cnt !== 4'd15) begin
          bad++; $display("FAIL sat_at15 got=%0d/%0d exp=15/15", bus4.branch_cnt, bus4.taken_cnt); end
      end
    end
    total++; if (miss != 0) begin bad++; $display("FAIL sat_jal_taken got=%0d misses exp=0", miss); end
    @(negedge clk); #1;
    total++; if (bus4.branch_cnt !== 4'd15 || bus4.taken_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_final got=%0d/%0d exp=15/15", bus4.branch_cnt, bus4.taken_cnt); end
  endtask

  initial begin
    total = 0; bad = 0; exp_branch = 0; exp_taken = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_beq_taken();
    test_bltu_not_taken();
    test_bge_wait();
    test_kill();
    test_illegal();
    test_back_to_back();
    test_jalr_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
